wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, 64, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_valid  input  1  MEM/WB holds an instruction this cycle.
REQ-005 mem_ready  output  1  stage accepts the instruction; equals !stall.
REQ-006 stall  input  1  hazard-unit hold request; blocks acceptance.
REQ-007 flush  input  1  kill the instruction presented this cycle.
REQ-008 mem_rd  input  5  destination register address.
REQ-009 mem_rd_wr_en  input  1  instruction writes a destination register.
REQ-010 mem_wb_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-011 mem_alu_result  input  32  ALU result; bits [1:0] are the load byte offset.
REQ-012 mem_load_data  input  32  raw aligned memory word.
REQ-013 mem_funct3  input  3  load type for load instructions.
REQ-014 mem_pc_plus4  input  32  link value for JAL/JALR.
REQ-015 rd  output  5  register-file write address.
REQ-016 rd_wr_data  output  32  register-file write data.
REQ-017 rd_wr_en  output  1  register-file write enable, one-cycle pulse per write.
REQ-018 load_err  output  1  one-cycle pulse: misaligned or illegal load dropped.
REQ-019 instret  output  CNT_W  count of retired instructions.

Function
REQ-020 Accept occurs in a cycle when mem_valid && mem_ready && !flush && !rst.
REQ-021 All outputs are registered; results appear exactly one cycle after accept.
REQ-022 The cycle after an accept: rd = mem_rd and rd_wr_data = the selected result.
REQ-023 rd_wr_en = mem_rd_wr_en && (mem_rd != 0) && !load fault, registered.
REQ-024 In any cycle without an accept, rd_wr_en is 0 next cycle; rd and rd_wr_data hold.
REQ-025 Load extraction: LB 000 sign-extends byte [8*off+7:8*off]; LBU 100 zero-extends it.
REQ-026 LH 001 and LHU 101 select halfword [16*off[1]+15:16*off[1]], sign- or zero-extended.
REQ-027 LW 010 passes mem_load_data unchanged.
REQ-028 Load fault: LH/LHU with off[0]=1, LW with off!=0, or funct3 in {011,110,111}.
REQ-029 Load fault on an accepted load: no write, load_err = 1 for one cycle, not retired.
REQ-030 load_err is 0 for non-load instructions regardless of funct3.
REQ-031 instret increments by 1 the cycle after each accept without load fault, including rd = x0 writes.
REQ-032 instret wraps from 2^CNT_W-1 to 0 without error.
REQ-033 flush drops the presented instruction: no write, no retire, no load_err.
REQ-034 flush and stall together: treated as flush.
REQ-035 Back-to-back accepts give back-to-back rd_wr_en pulses, one per instruction.

Reset
REQ-036 On rst: rd = 0, rd_wr_data = 0, rd_wr_en = 0, load_err = 0, instret = 0.
REQ-037 rst has priority over accept; an instruction presented during rst is lost.
REQ-038 mem_ready follows !stall combinationally, including during rst.

Verification
REQ-039 ALU op, rd=5, alu=0x1234_5678, wb_sel=00 -> next cycle rd_wr_en=1, rd=5, data=0x1234_5678, instret=1.
REQ-040 LB, off=3, word=0x80FF_0000 -> data=0xFFFF_FF80; LBU same -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF.
REQ-041 LW, off=2 -> rd_wr_en=0, load_err=1 one cycle, instret unchanged.
REQ-042 JAL, rd=1, pc_plus4=0x0000_0104, stall=1 for 2 cycles then 0 -> single write of 0x104 after release.
REQ-043 Accepts on cycles 1,2,3 with flush on cycle 2 -> writes on cycles 2 and 4 only, instret=2.
REQ-044 instret preloaded near wrap (CNT_W=4, 15 retires) plus one retire -> instret=0; rst mid-stream clears all outputs.

Source files
------------

// File: rtl/wb_stage.sv
// Pipeline write-back stage: picks the result source, extracts load data, and
// drives one registered register-file write per accepted instruction. It also counts retired instructions.
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       mem_rd,
    input  logic             mem_rd_wr_en,
    input  logic [1:0]       mem_wb_sel,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_load_data,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_pc_plus4,
    output logic [4:0]       rd,
    output logic [31:0]      rd_wr_data,
    output logic             rd_wr_en,
    output logic             load_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             accept;
    logic             is_load;
    logic [1:0]       off;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_value;
    logic             ld_fault;
    logic [31:0]      result;

    logic [4:0]       rd_q;
    logic [31:0]      rd_wr_data_q;
    logic             rd_wr_en_q;
    logic             load_err_q;
    logic [CNT_W-1:0] instret_q;

    // Handshake: an instruction transfers when mem_valid && mem_ready in a
    // cycle with no flush and no reset; mem_ready depends only on stall.
    assign mem_ready = !stall;
    assign accept    = mem_valid && mem_ready && !flush;
    assign is_load   = (mem_wb_sel == 2'b01);
    assign off       = mem_alu_result[1:0];

    always_comb begin
        case (off)
            2'd1:    ld_byte = mem_load_data[15:8];
            2'd2:    ld_byte = mem_load_data[23:16];
            2'd3:    ld_byte = mem_load_data[31:24];
            default: ld_byte = mem_load_data[7:0];
        endcase
        ld_half  = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        ld_value = mem_load_data;
        ld_fault = 1'b0;
        case (mem_funct3)
            3'b000: ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_value = {24'b0, ld_byte};
            3'b001: begin
                ld_value = {{16{ld_half[15]}}, ld_half};
                ld_fault = off[0];
            end
            3'b101: begin
                ld_value = {16'b0, ld_half};
                ld_fault = off[0];
            end
            3'b010:  ld_fault = (off != 2'd0);
            default: ld_fault = 1'b1;
        endcase
    end

    always_comb begin
        case (mem_wb_sel)
            2'b01:   result = ld_value;
            2'b10:   result = mem_pc_plus4;
            default: result = mem_alu_result;
        endcase
    end

    // A faulted load leaves rd/rd_wr_data untouched; only load_err reports it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q         <= 5'd0;
            rd_wr_data_q <= 32'd0;
            rd_wr_en_q   <= 1'b0;
            load_err_q   <= 1'b0;
            instret_q    <= '0;
        end else begin
            rd_wr_en_q <= 1'b0;
            load_err_q <= 1'b0;
            if (accept) begin
                if (is_load && ld_fault) begin
                    load_err_q <= 1'b1;
                end else begin
                    rd_q         <= mem_rd;
                    rd_wr_data_q <= result;
                    rd_wr_en_q   <= mem_rd_wr_en && (mem_rd != 5'd0);
                    instret_q    <= instret_q + CNT_ONE;
                end
            end
        end
    end

    assign rd         = rd_q;
    assign rd_wr_data = rd_wr_data_q;
    assign rd_wr_en   = rd_wr_en_q;
    assign load_err   = load_err_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage, checked against a behavioural
// model; a second 4-bit-counter instance shares the inputs to observe instret wrap.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_ready_s;
    logic        stall;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_rd_wr_en;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_pc_plus4;
    logic [4:0]  rd;
    logic [31:0] rd_wr_data;
    logic        rd_wr_en;
    logic        load_err;
    logic [63:0] instret;
    logic [4:0]  rd_s;
    logic [31:0] rd_wr_data_s;
    logic        rd_wr_en_s;
    logic        load_err_s;
    logic [3:0]  instret_s;

    int checks;
    int errors;

    // Reference model state
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_we;
    logic        m_err;
    logic [63:0] m_cnt;
    logic        m_known;
    logic [36:0] exp_q[$];

    wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .stall(stall), .flush(flush), .mem_rd(mem_rd), .mem_rd_wr_en(mem_rd_wr_en),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
        .mem_pc_plus4(mem_pc_plus4), .rd(rd), .rd_wr_data(rd_wr_data),
        .rd_wr_en(rd_wr_en), .load_err(load_err), .instret(instret)
    );

    wb_stage #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready_s),
        .stall(stall), .flush(flush), .mem_rd(mem_rd), .mem_rd_wr_en(mem_rd_wr_en),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
        .mem_pc_plus4(mem_pc_plus4), .rd(rd_s), .rd_wr_data(rd_wr_data_s),
        .rd_wr_en(rd_wr_en_s), .load_err(load_err_s), .instret(instret_s)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load semantics from the rule text: shift the word right to the addressed
    // byte/halfword, then extend numerically.
    task automatic load_ref(input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, output logic fault,
                            output logic [31:0] value);
        logic [31:0] sh;
        int          sv;
        int unsigned bv;
        int unsigned hv;
        sh    = word >> (8 * int'(off));
        bv    = int'(sh) & 255;
        sh    = word >> (16 * int'(off / 2));
        hv    = int'(sh) & 65535;
        fault = 1'b1;
        value = 32'd0;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            fault = 1'b0;
            sv    = int'(bv);
            if (f3 == 3'd0 && bv > 127) sv = sv - 256;
            value = 32'(sv);
        end else if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 0)) begin
            fault = 1'b0;
            sv    = int'(hv);
            if (f3 == 3'd1 && hv > 32767) sv = sv - 65536;
            value = 32'(sv);
        end else if (f3 == 3'd2 && off == 2'd0) begin
            fault = 1'b0;
            value = word;
        end
    endtask

    // Driver: applies one cycle of inputs, advances the model, checks outputs.
    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic [4:0] rdv, input logic we, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [2:0] f3, input logic [31:0] pc);
        logic        fault;
        logic [31:0] lval;
        logic [31:0] res;
        logic [36:0] ent;
        @(negedge clk);
        rst = r; mem_valid = v; stall = s; flush = f; mem_rd = rdv;
        mem_rd_wr_en = we; mem_wb_sel = sel; mem_alu_result = alu;
        mem_load_data = ld; mem_funct3 = f3; mem_pc_plus4 = pc;
        #1;
        check("mem_ready", 64'(mem_ready), 64'(!s));
        check("mem_ready_s", 64'(mem_ready_s), 64'(!s));
        load_ref(f3, alu[1:0], ld, fault, lval);
        res = (sel == 2'b01) ? lval : (sel == 2'b10) ? pc : alu;
        m_we  = 1'b0;
        m_err = 1'b0;
        if (r) begin
            m_rd = 5'd0; m_data = 32'd0; m_cnt = 64'd0; m_known = 1'b1;
            exp_q.delete();
        end else if (v && !s && !f) begin
            if (sel == 2'b01 && fault) begin
                m_err   = 1'b1;
                m_known = 1'b0;
            end else begin
                m_rd    = rdv;
                m_data  = res;
                m_we    = we && (rdv != 5'd0);
                m_cnt   = m_cnt + 64'd1;
                m_known = 1'b1;
                if (m_we) exp_q.push_back({rdv, res});
            end
        end
        @(posedge clk);
        #1;
        check("rd_wr_en", 64'(rd_wr_en), 64'(m_we));
        check("load_err", 64'(load_err), 64'(m_err));
        check("instret", instret, m_cnt);
        check("instret_s", 64'(instret_s), 64'(m_cnt[3:0]));
        if (m_known) begin
            check("rd", 64'(rd), 64'(m_rd));
            check("rd_wr_data", 64'(rd_wr_data), 64'(m_data));
        end
        if (rd_wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(1), 64'(0));
            end else begin
                ent = exp_q.pop_front();
                check("wr_scoreboard", 64'({rd, rd_wr_data}), 64'(ent));
            end
        end
    endtask

    task automatic alu_op(input logic [4:0] rdv, input logic [31:0] alu);
        step(0, 1, 0, 0, rdv, 1, 2'b00, alu, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 5'd0, 0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 5'd0, 0, 2'b00, 32'd0, 32'd0, 3'd0, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0;
        m_rd = 0; m_data = 0; m_we = 0; m_err = 0; m_cnt = 0; m_known = 0;
        rst = 1; mem_valid = 0; stall = 0; flush = 0; mem_rd = 0; mem_rd_wr_en = 0;
        mem_wb_sel = 0; mem_alu_result = 0; mem_load_data = 0; mem_funct3 = 0;
        mem_pc_plus4 = 0;

        // Reset state, with a valid instruction presented that must be lost
        step(1, 1, 0, 0, 5'd7, 1, 2'b00, 32'hDEAD_BEEF, 32'd0, 3'd0, 32'd0);
        check("reset_rd", 64'(rd), 64'd0);
        check("reset_instret", instret, 64'd0);
        idle();

        // ALU write
        alu_op(5'd5, 32'h1234_5678);
        check("alu_data", 64'(rd_wr_data), 64'h1234_5678);
        check("alu_instret", instret, 64'd1);

        // Load extraction examples
        step(0, 1, 0, 0, 5'd3, 1, 2'b01, 32'h0000_0003, 32'h80FF_0000, 3'b000, 32'd0);
        check("lb_data", 64'(rd_wr_data), 64'hFFFF_FF80);
        step(0, 1, 0, 0, 5'd3, 1, 2'b01, 32'h0000_0003, 32'h80FF_0000, 3'b100, 32'd0);
        check("lbu_data", 64'(rd_wr_data), 64'h0000_0080);
        step(0, 1, 0, 0, 5'd3, 1, 2'b01, 32'h0000_0002, 32'h80FF_0000, 3'b001, 32'd0);
        check("lh_data", 64'(rd_wr_data), 64'hFFFF_80FF);

        // Misaligned LW
        step(0, 1, 0, 0, 5'd4, 1, 2'b01, 32'h0000_0002, 32'h1111_2222, 3'b010, 32'd0);
        check("lw_err", 64'(load_err), 64'd1);
        check("lw_instret", instret, 64'd4);
        idle();
        check("lw_err_pulse", 64'(load_err), 64'd0);

        // Illegal load funct3 vs non-load with same funct3
        step(0, 1, 0, 0, 5'd4, 1, 2'b01, 32'd0, 32'd0, 3'b111, 32'd0);
        step(0, 1, 0, 0, 5'd4, 1, 2'b00, 32'd0, 32'd0, 3'b111, 32'd0);
        check("nonload_no_err", 64'(load_err), 64'd0);

        // JAL held by stall for two cycles
        step(0, 1, 1, 0, 5'd1, 1, 2'b10, 32'd0, 32'd0, 3'd0, 32'h0000_0104);
        step(0, 1, 1, 0, 5'd1, 1, 2'b10, 32'd0, 32'd0, 3'd0, 32'h0000_0104);
        step(0, 1, 0, 0, 5'd1, 1, 2'b10, 32'd0, 32'd0, 3'd0, 32'h0000_0104);
        check("jal_data", 64'(rd_wr_data), 64'h104);
        idle();

        // Accept, flush(+stall), accept
        do_reset();
        alu_op(5'd2, 32'hA);
        step(0, 1, 1, 1, 5'd3, 1, 2'b00, 32'hB, 32'd0, 3'd0, 32'd0);
        alu_op(5'd4, 32'hC);
        check("flush_instret", instret, 64'd2);

        // x0 write retires without a write pulse
        alu_op(5'd0, 32'h55);
        check("x0_no_write", 64'(rd_wr_en), 64'd0);
        check("x0_instret", instret, 64'd3);

        // Counter wrap on the 4-bit instance: 15 retires then one more
        do_reset();
        for (int i = 0; i < 15; i++) alu_op(5'(i + 1), 32'(i));
        check("wrap_pre", 64'(instret_s), 64'd15);
        alu_op(5'd9, 32'h99);
        check("wrap_zero", 64'(instret_s), 64'd0);
        check("wrap_wide", instret, 64'd16);

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom);
        end
        idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
